// File: rtl/serv_wb_timer_pkg.sv
// rtl/serv_wb_timer_pkg.sv - shared register map, CTRL layout and byte-merge helper for the timer
package serv_wb_timer_pkg;

   localparam logic [2:0] ADR_MTIME_LO = 3'd0;
   localparam logic [2:0] ADR_MTIME_HI = 3'd1;
   localparam logic [2:0] ADR_CMP_LO   = 3'd2;
   localparam logic [2:0] ADR_CMP_HI   = 3'd3;
   localparam logic [2:0] ADR_CTRL     = 3'd4;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIV_LSB = 8;

   // All-ones compare value keeps the interrupt quiet out of reset
   localparam logic [63:0] CMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

   // Replace only the bytes whose select bit is set
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/serv_wb_timer_presc.sv
// rtl/serv_wb_timer_presc.sv - prescaler counter producing the mtime tick strobe
module serv_wb_timer_presc
   import serv_wb_timer_pkg::*;
#(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [PRESC_W-1:0] div,
   input  logic               clr,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;

   // Terminal count reached while enabled: mtime advances on this edge
   assign tick = en & (cnt == div);

   // Count up to div then restart; a CTRL write restarts the period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serv_wb_timer.sv
// rtl/serv_wb_timer.sv - Wishbone timer responder: mtime, mtimecmp, CTRL and level interrupt
module serv_wb_timer
   import serv_wb_timer_pkg::*;
#(
   parameter int          PRESC_W = 8,
   parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [2:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_irq
);

   // Implemented CTRL bits: en plus the divide field; everything else reads 0
   localparam logic [31:0] CTRL_MASK =
      (((32'd1 << PRESC_W) - 32'd1) << CTRL_DIV_LSB) | (32'd1 << CTRL_EN_BIT);

   logic [63:0] mtime, mtime_inc, mtime_nxt;
   logic [63:0] mtimecmp, cmp_nxt;
   logic [31:0] ctrl, ctrl_nxt;
   logic [31:0] hi_shadow;
   logic [31:0] rd_mux;
   logic        accept, wr_acc, rd_acc, tick, presc_clr;

   assign accept    = i_wb_cyc & ~o_wb_ack;
   assign wr_acc    = accept & i_wb_we;
   assign rd_acc    = accept & ~i_wb_we;
   assign presc_clr = wr_acc & (i_wb_adr == ADR_CTRL);

   serv_wb_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (ctrl[CTRL_EN_BIT]),
      .div   (ctrl[CTRL_DIV_LSB +: PRESC_W]),
      .clr   (presc_clr),
      .tick  (tick)
   );

   // Next register values: tick increment first, then written bytes override it
   always_comb begin
      mtime_inc = tick ? mtime + 64'd1 : mtime;
      mtime_nxt = mtime_inc;
      cmp_nxt   = mtimecmp;
      ctrl_nxt  = ctrl;
      if (wr_acc) begin
         case (i_wb_adr)
            ADR_MTIME_LO: mtime_nxt[31:0]  = byte_merge(mtime_inc[31:0], i_wb_dat, i_wb_sel);
            ADR_MTIME_HI: mtime_nxt[63:32] = byte_merge(mtime_inc[63:32], i_wb_dat, i_wb_sel);
            ADR_CMP_LO:   cmp_nxt[31:0]    = byte_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
            ADR_CMP_HI:   cmp_nxt[63:32]   = byte_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
            ADR_CTRL:     ctrl_nxt         = byte_merge(ctrl, i_wb_dat, i_wb_sel) & CTRL_MASK;
            default: ;
         endcase
      end
   end

   // Read data select; MTIME_HI comes from the shadow captured by the last LO read
   always_comb begin
      rd_mux = 32'd0;
      case (i_wb_adr)
         ADR_MTIME_LO: rd_mux = mtime[31:0];
         ADR_MTIME_HI: rd_mux = hi_shadow;
         ADR_CMP_LO:   rd_mux = mtimecmp[31:0];
         ADR_CMP_HI:   rd_mux = mtimecmp[63:32];
         ADR_CTRL:     rd_mux = ctrl;
         default:      rd_mux = 32'd0;
      endcase
   end

   // Timer state registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mtime    <= 64'd0;
         mtimecmp <= CMP_RST;
         ctrl     <= 32'd1 << CTRL_EN_BIT;
      end else begin
         mtime    <= mtime_nxt;
         mtimecmp <= cmp_nxt;
         ctrl     <= ctrl_nxt;
      end
   end

   // Bus response: one-cycle ack, read data held until the next read accept
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_rdt  <= 32'd0;
         hi_shadow <= 32'd0;
      end else begin
         o_wb_ack <= accept;
         if (rd_acc) o_wb_rdt <= rd_mux;
         if (rd_acc && i_wb_adr == ADR_MTIME_LO) hi_shadow <= mtime[63:32];
      end
   end

   // Level interrupt from an unsigned compare of the current registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_irq <= 1'b0;
      else          o_irq <= (mtime >= mtimecmp);
   end

endmodule

// File: tb/tb_serv_wb_timer.sv
// tb/tb_serv_wb_timer.sv - directed self-checking bench for serv_wb_timer
module tb_serv_wb_timer;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [2:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic [3:0]  i_wb_sel;
   logic        i_wb_we;
   logic        i_wb_cyc;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic        o_irq;

   int total = 0;
   int bad   = 0;
   logic [31:0] rd;

   serv_wb_timer dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wb_adr (i_wb_adr),
      .i_wb_dat (i_wb_dat),
      .i_wb_sel (i_wb_sel),
      .i_wb_we  (i_wb_we),
      .i_wb_cyc (i_wb_cyc),
      .o_wb_rdt (o_wb_rdt),
      .o_wb_ack (o_wb_ack),
      .o_irq    (o_irq)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; one accept edge plus the ack-drop edge, returns at a negedge
   task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdata);
      i_wb_cyc = 1'b1;
      i_wb_we  = we;
      i_wb_adr = adr;
      i_wb_dat = dat;
      i_wb_sel = sel;
      @(posedge i_clk);
      #1;
      check("ack", 64'(o_wb_ack), 64'd1);
      rdata    = o_wb_rdt;
      i_wb_cyc = 1'b0;
      i_wb_we  = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic wb_wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, dat, sel, dummy);
   endtask

   task automatic wb_rd(input logic [2:0] adr, output logic [31:0] data);
      wb_xfer(1'b0, adr, 32'd0, 4'hF, data);
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_wb_cyc = 1'b0;
      i_wb_we  = 1'b0;
      i_wb_adr = 3'd0;
      i_wb_dat = 32'd0;
      i_wb_sel = 4'h0;
      repeat (3) @(negedge i_clk);
      check("rst_ack", 64'(o_wb_ack), 64'd0);
      check("rst_irq", 64'(o_irq), 64'd0);
      check("rst_rdt", 64'(o_wb_rdt), 64'd0);

      // Free run from reset, div=0
      i_rst_n = 1'b1;
      repeat (10) @(negedge i_clk);
      wb_rd(3'd0, rd);
      check("t1_lo", 64'(rd), 64'd10);
      check("t1_irq", 64'(o_irq), 64'd0);

      // div=3: one tick per 4 cycles
      wb_wr(3'd1, 32'd0, 4'hF);
      wb_wr(3'd0, 32'd0, 4'hF);
      wb_wr(3'd4, 32'h0000_0301, 4'hF);
      wb_rd(3'd0, rd);
      check("t2_lo0", 64'(rd), 64'd2);
      repeat (38) @(negedge i_clk);
      wb_rd(3'd0, rd);
      check("t2_lo40", 64'(rd), 64'd12);
      wb_rd(3'd4, rd);
      check("t2_ctrl", 64'(rd), 64'h301);

      // Frozen counter, then 64-bit wrap once re-enabled
      wb_wr(3'd4, 32'd0, 4'hF);
      wb_wr(3'd1, 32'hFFFF_FFFF, 4'hF);
      wb_wr(3'd0, 32'hFFFF_FFFF, 4'hF);
      wb_rd(3'd0, rd);
      check("frz_lo", 64'(rd), 64'hFFFF_FFFF);
      wb_wr(3'd4, 32'd1, 4'hF);
      wb_rd(3'd0, rd);
      check("wrap_lo", 64'(rd), 64'd0);
      wb_rd(3'd1, rd);
      check("wrap_hi", 64'(rd), 64'd0);

      // Carry into HI via atomic LO/HI read
      wb_wr(3'd1, 32'd0, 4'hF);
      wb_wr(3'd0, 32'hFFFF_FFFE, 4'hF);
      @(negedge i_clk);
      wb_rd(3'd0, rd);
      check("t3_lo", 64'(rd), 64'd0);
      wb_rd(3'd1, rd);
      check("t3_hi", 64'(rd), 64'd1);

      // Interrupt timing against mtimecmp
      wb_wr(3'd4, 32'd0, 4'hF);
      wb_wr(3'd3, 32'd0, 4'hF);
      wb_wr(3'd2, 32'h20, 4'hF);
      wb_wr(3'd1, 32'd0, 4'hF);
      wb_wr(3'd0, 32'h10, 4'hF);
      check("t4_irq_idle", 64'(o_irq), 64'd0);
      wb_wr(3'd4, 32'd1, 4'hF);
      repeat (14) @(negedge i_clk);
      check("t4_irq_1f", 64'(o_irq), 64'd0);
      @(negedge i_clk);
      check("t4_irq_20", 64'(o_irq), 64'd0);
      @(negedge i_clk);
      check("t4_irq_rise", 64'(o_irq), 64'd1);
      wb_wr(3'd3, 32'd1, 4'hF);
      check("t4_irq_fall", 64'(o_irq), 64'd0);

      // Byte-enable writes
      wb_wr(3'd2, 32'hFFFF_FFFF, 4'hF);
      wb_wr(3'd2, 32'hAABB_CCDD, 4'b0010);
      wb_rd(3'd2, rd);
      check("t5_byte", 64'(rd), 64'hFFFF_CCFF);
      wb_wr(3'd2, 32'd0, 4'b0000);
      wb_rd(3'd2, rd);
      check("t5_sel0", 64'(rd), 64'hFFFF_CCFF);
      wb_wr(3'd7, 32'h1234_5678, 4'hF);

      // Held cyc: ack every other cycle
      i_wb_cyc = 1'b1;
      i_wb_we  = 1'b0;
      i_wb_adr = 3'd2;
      for (int i = 0; i < 6; i++) begin
         check("t6_ack_pat", 64'(o_wb_ack), 64'(i % 2));
         @(negedge i_clk);
      end
      i_wb_cyc = 1'b0;
      wb_rd(3'd6, rd);
      check("t6_rsvd", 64'(rd), 64'd0);

      // Reset while ack is high
      i_wb_cyc = 1'b1;
      i_wb_adr = 3'd2;
      @(posedge i_clk);
      #1;
      check("t6_ack_pre", 64'(o_wb_ack), 64'd1);
      check("t6_rdt_pre", 64'(o_wb_rdt), 64'hFFFF_CCFF);
      i_rst_n = 1'b0;
      #1;
      check("t6_ack_rst", 64'(o_wb_ack), 64'd0);
      check("t6_rdt_rst", 64'(o_wb_rdt), 64'd0);
      i_wb_cyc = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      wb_rd(3'd2, rd);
      check("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
      wb_rd(3'd3, rd);
      check("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
      wb_rd(3'd4, rd);
      check("rst_ctrl", 64'(rd), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
